// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with one buffered entry per output lane.
// Each lane has its own valid/ready handshake, so a stalled consumer blocks
// only transfers aimed at its own lane.
// Optional: define DEMUX_XFER_CNT_EN to add per-lane 16-bit drain counters
// on port xfer_cnt.
module demux_1x4_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
`ifdef DEMUX_XFER_CNT_EN
    output logic [4*16-1:0]    xfer_cnt,
`endif
    output logic [4*WIDTH-1:0] out_data
);

    logic [3:0]       full_q, full_d;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             accept;

    // Upstream handshake: the selected lane is free or is being drained this
    // cycle. Deliberately independent of in_valid.
    always_comb begin
        in_ready = ~full_q[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
    end

    // Per-lane load/drain decode and next-state occupancy.
    always_comb begin
        load   = '0;
        drain  = '0;
        full_d = full_q;
        for (int i = 0; i < 4; i++) begin
            load[i]   = accept & (in_sel == 2'(i));
            drain[i]  = full_q[i] & out_ready[i];
            // A load in the same cycle as a drain keeps the lane full.
            full_d[i] = load[i] | (full_q[i] & ~drain[i]);
        end
    end

    // Lane state registers; data only changes on an accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    // Outputs come straight from the lane flops.
    always_comb begin
        out_valid = full_q;
        out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[WIDTH*i +: WIDTH] = data_q[i];
        end
    end

`ifdef DEMUX_XFER_CNT_EN
    logic [15:0] cnt_q [4];

    // Per-lane drain counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Pack counters onto the output bus.
    always_comb begin
        xfer_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            xfer_cnt[16*i +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Directed self-checking bench for demux_1x4_reg. Inputs are driven on the
// falling edge; registered outputs are sampled on the falling edge after the
// rising edge that updated them.
module tb_demux_1x4_reg;

    localparam int unsigned WIDTH = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_XFER_CNT_EN
    logic [4*16-1:0]    xfer_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    demux_1x4_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DEMUX_XFER_CNT_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lane(input int i);
        return out_data[WIDTH*i +: WIDTH];
    endfunction

`ifdef DEMUX_XFER_CNT_EN
    function automatic logic [15:0] cnt(input int i);
        return xfer_cnt[16*i +: 16];
    endfunction
`endif

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", out_data);
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready sel=%0d: got %b expected 1", s, in_ready);
            end
        end
`ifdef DEMUX_XFER_CNT_EN
        n_checks++;
        if (xfer_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected 0", xfer_cnt);
        end
`endif
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'h0BAD0BAD;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 4'b0100 || lane(2) !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL single_hold cyc=%0d: got valid=%b lane2=%h expected 0100/deadbeef",
                         c, out_valid, lane(2));
            end
            @(negedge clk);
        end
        out_ready = 4'b0100;
        @(negedge clk);
        out_ready = 4'b0000;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_drain: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (lane(2) !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_keep_data: got %h expected deadbeef", lane(2));
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h11;
        @(negedge clk);
        in_data = 32'h99;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_blocked_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 4'b0010 || lane(1) !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_lane1_hold: got valid=%b lane1=%h expected 0010/11",
                     out_valid, lane(1));
        end
        in_sel  = 2'd3;
        in_data = 32'h33;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_other_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1010 || lane(3) !== 32'h33 || lane(1) !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_two_lanes: got valid=%b lane1=%h lane3=%h expected 1010/11/33",
                     out_valid, lane(1), lane(3));
        end
        out_ready = 4'b1111;
        @(negedge clk);
        out_ready = 4'b0000;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_drain_all: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_streaming();
        @(negedge clk);
        out_ready = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                n_checks++;
                if (out_valid[0] !== 1'b1 || lane(0) !== 32'(k - 1)) begin
                    n_fail++;
                    $display("FAIL stream_word k=%0d: got valid=%b lane0=%h expected 1/%h",
                             k, out_valid[0], lane(0), k - 1);
                end
            end
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_data  = 32'(k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready k=%0d: got %b expected 1", k, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b1 || lane(0) !== 32'd8) begin
            n_fail++;
            $display("FAIL stream_last: got valid=%b lane0=%h expected 1/8", out_valid[0], lane(0));
        end
        @(negedge clk);
        out_ready = 4'b0000;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL stream_empty: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'hA0A0A0A0;
        @(negedge clk);
        in_sel  = 2'd3;
        in_data = 32'hB3B3B3B3;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 4'b1001) begin
            n_fail++;
            $display("FAIL mid_setup: got %b expected 1001", out_valid);
        end
        reset   = 1'b1;
        in_sel  = 2'd0;
        in_data = 32'hC0C0C0C0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b0000 || out_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b data=%h expected 0000/0", out_valid, out_data);
        end
    endtask

`ifdef DEMUX_XFER_CNT_EN
    task automatic test_xfer_cnt();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        for (int k = 0; k < 65537; k++) begin
            in_data = 32'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 4'b0000;
        n_checks++;
        if (cnt(1) !== 16'd1) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %h expected 0001", cnt(1));
        end
        n_checks++;
        if (cnt(0) !== 16'd0 || cnt(2) !== 16'd0 || cnt(3) !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_other: got %h expected lanes 0,2,3 zero", xfer_cnt);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (xfer_cnt !== '0) begin
            n_fail++;
            $display("FAIL cnt_reset: got %h expected 0", xfer_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_reset_mid();
`ifdef DEMUX_XFER_CNT_EN
        test_xfer_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
